// File: rtl/r_type_encoder_loader_if.sv
// R-type field handshake bus: one field set per transfer, moved when in_valid && in_ready.
// master = field source (program loader front end); slave = r_type_encoder_loader.
// Ports: in_valid/in_ready handshake, rd/rs1/rs2/funct3/funct7 field payload.
interface r_type_encoder_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;

  modport master (
    output in_valid, rd, rs1, rs2, funct3, funct7,
    input  in_ready
  );

  modport slave (
    input  in_valid, rd, rs1, rs2, funct3, funct7,
    output in_ready
  );
endinterface

// File: rtl/r_type_encoder_loader.sv
// Packs R-type fields into RV32I words and writes legal ones to sequential instruction-memory addresses.
// Latency: accept at edge N -> mem_we (legal) or err (illegal) in cycle N+1; word_count moves at edge N+1.
// Backpressure: in_ready low during reset, in the start cycle, once DEPTH words are committed, and in FULL.
// Ports: clk, reset (async, active-high), start (rewind pulse), in_if (field handshake, slave side),
//        mem_we/mem_addr/mem_wdata (memory write port), word_count, full, err, err_count (status).
module r_type_encoder_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned BASE_ADDR  = 0,
  parameter logic [6:0]  OPCODE     = 7'b0110011
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  r_type_encoder_loader_if.slave in_if,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  full,
  output logic                  err,
  output logic [7:0]            err_count
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic {S_LOAD = 1'b0, S_FULL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  err_q, err_d;
  logic [7:0]            err_count_q, err_count_d;

  logic                  legal;
  logic                  in_ready_c;
  logic                  accept;
  // Words committed once the write currently on the bus lands; this is what
  // addresses the next write and what decides whether another accept fits.
  logic [ADDR_WIDTH:0]   count_pend;

  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = 1'b0;
    in_ready_c  = 1'b0;

    legal = (in_if.funct7 == 7'b0000000) ||
            ((in_if.funct7 == 7'b0100000) &&
             ((in_if.funct3 == 3'b000) || (in_if.funct3 == 3'b101)));

    count_pend = word_count_q + CW'(mem_we_q);

    case (state_q)
      S_LOAD: begin
        // The cycle carrying the DEPTH-th write must already refuse new
        // fields, otherwise a held in_valid would slip one word past DEPTH.
        in_ready_c = !reset && !start && (count_pend < DEPTH_C);
        if (!start && (count_pend == DEPTH_C)) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (start) begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase

    accept = in_if.in_valid && in_ready_c;

    if (accept && legal) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = BASE_C + count_pend[ADDR_WIDTH-1:0];
      mem_wdata_d = {in_if.funct7, in_if.rs2, in_if.rs1, in_if.funct3, in_if.rd, OPCODE};
    end
    err_d = accept && !legal;

    // start clears the count even while the previous accept's write lands.
    word_count_d = start ? '0 : count_pend;

    if (start) begin
      err_count_d = '0;
    end else if (err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_LOAD;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE_C;
      mem_wdata_q  <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign in_if.in_ready = in_ready_c;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign word_count     = word_count_q;
  assign full           = (state_q == S_FULL);
  assign err            = err_q;
  assign err_count      = err_count_q;

endmodule
